// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result bundle between the control unit and the multi-cycle ALU.
interface alu_mc_if #(parameter int WIDTH = 8);
    logic             start;
    logic [2:0]       select;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             busy;
    logic             done;
    modport master (output start, select, data1, data2, input result, zero, carry, busy, done);
    modport slave (input start, select, data1, data2, output result, zero, carry, busy, done);
endinterface

// File: rtl/alu_mc.sv
// alu_mc: clocked ALU with single-cycle logic/arith ops and multi-cycle shift-add multiply and shifter.
module alu_mc #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [0:0] IDLE = 1'b0, EXEC = 1'b1;
    localparam logic [2:0] OP_FWD = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                           OP_SUB = 3'b100, OP_MUL = 3'b101, OP_SHF = 3'b110;
    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10;
    logic [0:0]         state;
    logic               is_mul;
    logic [1:0]         mode;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   sh;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   r1;
    logic               c1;
    logic               multi;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   sh_nx;
    logic               sh_co;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c;
    assign amt   = bus.data2[SHAMT_W-1:0];
    assign multi = (bus.select == OP_MUL) || (bus.select == OP_SHF && amt != '0);
    always_comb begin
        r1 = '0;
        c1 = 1'b0;
        case (bus.select)
            OP_FWD:  r1 = bus.data2;
            OP_ADD:  {c1, r1} = {1'b0, bus.data1} + {1'b0, bus.data2};
            OP_AND:  r1 = bus.data1 & bus.data2;
            OP_OR:   r1 = bus.data1 | bus.data2;
            OP_SUB:  {c1, r1} = {1'b0, bus.data1} - {1'b0, bus.data2};
            OP_SHF:  r1 = bus.data1;
            default: r1 = '0;
        endcase
    end
    // Multiplier keeps {partial product, remaining multiplier} in one register, shifting right each step.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nx  = {sum, acc[WIDTH-1:1]};
        sh_co   = (mode == SLL) ? sh[WIDTH-1] : sh[0];
        sh_nx   = (mode == SLL) ? {sh[WIDTH-2:0], 1'b0} :
                  (mode == SRL) ? {1'b0, sh[WIDTH-1:1]} :
                  (mode == SRA) ? {sh[WIDTH-1], sh[WIDTH-1:1]} :
                                  {sh[0], sh[WIDTH-1:1]};
        fin_res = is_mul ? acc_nx[WIDTH-1:0] : sh_nx;
        fin_c   = is_mul ? |acc_nx[2*WIDTH-1:WIDTH] : sh_co;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            is_mul     <= 1'b0;
            mode       <= '0;
            cnt        <= '0;
            mcand      <= '0;
            sh         <= '0;
            acc        <= '0;
            bus.result <= '0;
            bus.zero   <= 1'b0;
            bus.carry  <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start && multi) begin
                    state    <= EXEC;
                    bus.busy <= 1'b1;
                    is_mul   <= bus.select == OP_MUL;
                    mode     <= bus.data2[WIDTH-1:WIDTH-2];
                    mcand    <= bus.data1;
                    acc      <= {{WIDTH{1'b0}}, bus.data2};
                    sh       <= bus.data1;
                    cnt      <= (bus.select == OP_MUL) ? CW'(WIDTH - 1) : CW'(amt) - CW'(1);
                end else if (bus.start) begin
                    bus.result <= r1;
                    bus.carry  <= c1;
                    bus.zero   <= r1 == '0;
                    bus.done   <= 1'b1;
                end
            end else begin
                acc <= acc_nx;
                sh  <= sh_nx;
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    state      <= IDLE;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    bus.result <= fin_res;
                    bus.carry  <= fin_c;
                    bus.zero   <= fin_res == '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks of alu_mc with WIDTH=8.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n = 0;
    int   fails = 0;
    int   cyc;
    alu_mc_if #(.WIDTH(8)) bus ();
    alu_mc #(.WIDTH(8), .SHAMT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        bus.select = sel;
        bus.data1  = a;
        bus.data2  = b;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
    endtask
    task automatic run_multi(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                             input bit pulse, output int cycles);
        issue(sel, a, b);
        chk("multi_busy_after_start", bus.busy, 1);
        chk("multi_done_after_start", bus.done, 0);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (pulse && i == 3) begin
                bus.start  = 1'b1;
                bus.select = 3'b001;
                bus.data1  = 8'hFF;
                bus.data2  = 8'hFF;
            end
            step();
            bus.start = 1'b0;
            cycles++;
            if (bus.done) break;
        end
    endtask
    initial begin
        bus.start  = 1'b0;
        bus.select = '0;
        bus.data1  = '0;
        bus.data2  = '0;
        repeat (2) step();
        chk("reset_result", bus.result, 0);
        chk("reset_zero", bus.zero, 0);
        chk("reset_carry", bus.carry, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b0;
        step();
        issue(3'b001, 8'hF0, 8'h20);
        chk("add_result", bus.result, 8'h10);
        chk("add_carry", bus.carry, 1);
        chk("add_zero", bus.zero, 0);
        chk("add_done", bus.done, 1);
        chk("add_busy", bus.busy, 0);
        step();
        chk("add_done_drop", bus.done, 0);
        chk("add_result_hold", bus.result, 8'h10);
        issue(3'b100, 8'h05, 8'h05);
        chk("sub_eq_result", bus.result, 8'h00);
        chk("sub_eq_zero", bus.zero, 1);
        chk("sub_eq_carry", bus.carry, 0);
        issue(3'b100, 8'h03, 8'h05);
        chk("sub_borrow_result", bus.result, 8'hFE);
        chk("sub_borrow_carry", bus.carry, 1);
        chk("sub_borrow_zero", bus.zero, 0);
        step();
        run_multi(3'b101, 8'h0D, 8'h0B, 1'b1, cyc);
        chk("mul1_cycles", cyc, 8);
        chk("mul1_result", bus.result, 8'h8F);
        chk("mul1_carry", bus.carry, 0);
        chk("mul1_zero", bus.zero, 0);
        chk("mul1_busy_end", bus.busy, 0);
        step();
        chk("mul1_done_drop", bus.done, 0);
        chk("mul1_no_queue_busy", bus.busy, 0);
        chk("mul1_result_hold", bus.result, 8'h8F);
        run_multi(3'b101, 8'h20, 8'h10, 1'b0, cyc);
        chk("mul2_cycles", cyc, 8);
        chk("mul2_result", bus.result, 8'h00);
        chk("mul2_carry", bus.carry, 1);
        chk("mul2_zero", bus.zero, 1);
        step();
        run_multi(3'b110, 8'h90, 8'h83, 1'b0, cyc);
        chk("sra_cycles", cyc, 3);
        chk("sra_result", bus.result, 8'hF2);
        chk("sra_carry", bus.carry, 0);
        step();
        run_multi(3'b110, 8'h01, 8'hC1, 1'b0, cyc);
        chk("ror_cycles", cyc, 1);
        chk("ror_result", bus.result, 8'h80);
        chk("ror_carry", bus.carry, 1);
        step();
        issue(3'b110, 8'h5A, 8'h00);
        chk("sll0_result", bus.result, 8'h5A);
        chk("sll0_carry", bus.carry, 0);
        chk("sll0_done", bus.done, 1);
        chk("sll0_busy", bus.busy, 0);
        step();
        bus.start  = 1'b1;
        bus.select = 3'b000;
        bus.data1  = 8'hFF;
        bus.data2  = 8'h2A;
        step();
        chk("b2b_fwd_result", bus.result, 8'h2A);
        chk("b2b_fwd_done", bus.done, 1);
        bus.select = 3'b010;
        bus.data1  = 8'h0F;
        bus.data2  = 8'h3C;
        step();
        chk("b2b_and_result", bus.result, 8'h0C);
        chk("b2b_and_done", bus.done, 1);
        bus.select = 3'b011;
        bus.data1  = 8'h09;
        bus.data2  = 8'h0C;
        step();
        bus.start = 1'b0;
        chk("b2b_or_result", bus.result, 8'h0D);
        chk("b2b_or_done", bus.done, 1);
        step();
        chk("b2b_done_drop", bus.done, 0);
        issue(3'b101, 8'h0D, 8'h0B);
        repeat (4) step();
        chk("rstmid_busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_result", bus.result, 0);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_done", bus.done, 0);
        chk("rstmid_carry", bus.carry, 0);
        chk("rstmid_zero", bus.zero, 0);
        step();
        rst = 1'b0;
        repeat (10) begin
            step();
            chk("rstmid_idle_busy", bus.busy, 0);
            chk("rstmid_idle_done", bus.done, 0);
        end
        issue(3'b001, 8'h01, 8'h01);
        chk("post_rst_add_result", bus.result, 8'h02);
        chk("post_rst_add_carry", bus.carry, 0);
        chk("post_rst_add_done", bus.done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
